rx_channel_hop_scheduler: RTL and testbench
===========================================

// Module: rx_channel_hop_scheduler
// PURPOSE
//  Sequences the RX channel modulator through a programmable list of channels (frequency hopping).
//  Counts accepted input samples and, after each dwell period, reprograms the phase increment.
//  Drives the modulator's phase-increment port (o_phase_inc / o_phase_inc_valid).
//  The update pulse never coincides with a sample strobe.
//  Sits beside the modulator on the RX sample path and observes the same i_valid.
// PARAMETERS
//  NUM_CHANNELS  4096  channels of the modulator; PHASE_WIDTH = $clog2(NUM_CHANNELS)
//  TABLE_DEPTH   16    entries in the hop table; IDX_WIDTH = $clog2(TABLE_DEPTH)
//  DWELL_WIDTH   16    width of the dwell (samples per hop) counter
// PORTS
//  i_clock          in   1            clock
//  i_reset          in   1            synchronous, active-high reset
//  i_cfg_wr         in   1            hop table write strobe
//  i_cfg_addr       in   IDX_WIDTH    hop table write address
//  i_cfg_chan       in   PHASE_WIDTH  channel (phase increment) written to table
//  i_cfg_len        in   IDX_WIDTH+1  entries used, 1..TABLE_DEPTH; sampled on i_start
//  i_cfg_dwell      in   DWELL_WIDTH  samples per hop, >=1; sampled on i_start
//  i_start          in   1            begin hopping from entry 0
//  i_stop           in   1            abort hopping, return to IDLE
//  i_valid          in   1            sample strobe entering the modulator
//  o_phase_inc      out  PHASE_WIDTH  phase increment to the modulator
//  o_phase_inc_valid out 1            one-cycle update pulse
//  o_hop_index      out  IDX_WIDTH    table entry currently applied
//  o_busy           out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE.
//  Registers: idx, dwell_cnt, len_q, dwell_q.
//  Table: TABLE_DEPTH x PHASE_WIDTH registers; not cleared by reset.
//  Table writes are accepted in any state.
//  A write to the entry due next is used if it lands at least 1 cycle before that entry is read.
//  FSM:
//   IDLE: on i_start, latch len_q and dwell_q; idx=0 -> PEND.
//     i_cfg_len==0 or i_cfg_dwell==0 -> i_start is ignored.
//   PEND: wait for a cycle with i_valid==0. In that cycle:
//     o_phase_inc_valid=1 for 1 cycle; o_phase_inc=table[idx]; o_hop_index=idx;
//     dwell_cnt=0 -> RUN.
//     Samples arriving while in PEND are not counted toward either dwell.
//   RUN: each i_valid increments dwell_cnt. When dwell_cnt==dwell_q-1 and i_valid=1:
//     idx <= (idx==len_q-1) ? 0 : idx+1 (wrap) -> PEND.
//  Pulse timing: the pulse leaves PEND 1 registered cycle after the last counted sample
//    (earliest cycle with i_valid low).
//  o_phase_inc holds its last value between pulses and after stop.
//  i_stop has priority over i_start and over every transition -> IDLE next cycle.
//    No pulse is issued that cycle.
//  i_start while busy is ignored.
//  Reset mid-hop: state returns to IDLE and outputs go to 0 on the next edge.
// CONFIGURATION
//  RX_HOP_COUNT_EN defined:
//    adds port o_hop_count (out, 32): number of pulses since the last i_start.
//    Cleared on reset and on i_start; saturates at 32'hFFFF_FFFF.
//  RX_HOP_COUNT_EN undefined: no port, no counter; all other behaviour identical.
// TESTING
//  1. Reset, no i_start, i_valid toggling -> o_phase_inc_valid never asserts; o_busy=0.
//  2. Table {5,9,17}, len=3, dwell=4, i_valid every other cycle ->
//     pulses carry 5,9,17,5,...; exactly 4 samples between pulses.
//  3. i_valid held high 10 cycles while in PEND ->
//     no pulse until the first low cycle; pulse occurs in that cycle.
//  4. i_stop in the same cycle as a dwell completion ->
//     no pulse; o_busy=0 next cycle; o_phase_inc keeps its prior value.
//  5. len=1, dwell=1, continuous i_valid with 1 gap per 3 cycles ->
//     every pulse carries table[0]; o_hop_index=0 throughout.
//  6. RX_HOP_COUNT_EN: 7 hops, then i_start re-issued after stop ->
//     o_hop_count reads 7, then 0.
//     i_start with len=0 -> ignored; o_busy stays 0.

Source files
------------

// File: rtl/rx_channel_hop_scheduler.sv
// Frequency-hop sequencer: steps the modulator phase increment through a hop table every dwell period.
// Optional feature macro: RX_HOP_COUNT_EN adds o_hop_count (saturating pulse count since last start).
module rx_channel_hop_scheduler #(
    parameter int NUM_CHANNELS = 4096,
    parameter int TABLE_DEPTH  = 16,
    parameter int DWELL_WIDTH  = 16,
    localparam int PHASE_WIDTH = $clog2(NUM_CHANNELS),
    localparam int IDX_WIDTH   = $clog2(TABLE_DEPTH)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_cfg_wr,
    input  logic [IDX_WIDTH-1:0]   i_cfg_addr,
    input  logic [PHASE_WIDTH-1:0] i_cfg_chan,
    input  logic [IDX_WIDTH:0]     i_cfg_len,
    input  logic [DWELL_WIDTH-1:0] i_cfg_dwell,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_valid,
    output logic [PHASE_WIDTH-1:0] o_phase_inc,
    output logic                   o_phase_inc_valid,
    output logic [IDX_WIDTH-1:0]   o_hop_index,
    output logic                   o_busy
`ifdef RX_HOP_COUNT_EN
    ,
    output logic [31:0]            o_hop_count
`endif
);

    localparam logic [IDX_WIDTH:0] LEN_MAX = (IDX_WIDTH+1)'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_WIDTH-1:0]   idx_reg, idx_next;
    logic [DWELL_WIDTH-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [IDX_WIDTH:0]     len_q_reg, len_q_next;
    logic [DWELL_WIDTH-1:0] dwell_q_reg, dwell_q_next;
    logic [PHASE_WIDTH-1:0] phase_reg;
    logic [IDX_WIDTH-1:0]   hop_index_reg;

    logic [PHASE_WIDTH-1:0] table_mem [TABLE_DEPTH];
    logic [PHASE_WIDTH-1:0] table_rd;
    logic                   pulse;
    logic                   start_ok;
    logic [IDX_WIDTH:0]     len_clamped;
    logic [IDX_WIDTH:0]     idx_last;
    logic [DWELL_WIDTH-1:0] dwell_last;

    // Table is plain registers: a write is visible to any read in a later cycle.
    always_ff @(posedge i_clock) begin
        if (i_cfg_wr) begin
            table_mem[i_cfg_addr] <= i_cfg_chan;
        end
    end

    assign table_rd    = table_mem[idx_reg];
    assign start_ok    = i_start && (i_cfg_len != '0) && (i_cfg_dwell != '0);
    assign len_clamped = (i_cfg_len > LEN_MAX) ? LEN_MAX : i_cfg_len;
    assign idx_last    = len_q_reg - 1'b1;
    assign dwell_last  = dwell_q_reg - 1'b1;

    // The update is issued combinationally in the first sample-free PEND cycle,
    // so it can never overlap a sample strobe.
    assign pulse = (state_reg == PEND) && !i_valid && !i_stop && !i_reset;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        dwell_cnt_next = dwell_cnt_reg;
        len_q_next     = len_q_reg;
        dwell_q_next   = dwell_q_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    len_q_next   = len_clamped;
                    dwell_q_next = i_cfg_dwell;
                    idx_next     = '0;
                    state_next   = PEND;
                end
            end
            PEND: begin
                if (!i_valid) begin
                    dwell_cnt_next = '0;
                    state_next     = RUN;
                end
            end
            RUN: begin
                if (i_valid) begin
                    if (dwell_cnt_reg == dwell_last) begin
                        idx_next   = ({1'b0, idx_reg} == idx_last) ? '0 : idx_reg + 1'b1;
                        state_next = PEND;
                    end else begin
                        dwell_cnt_next = dwell_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (i_stop) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            dwell_cnt_reg <= '0;
            len_q_reg     <= '0;
            dwell_q_reg   <= '0;
            phase_reg     <= '0;
            hop_index_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            dwell_cnt_reg <= dwell_cnt_next;
            len_q_reg     <= len_q_next;
            dwell_q_reg   <= dwell_q_next;
            if (pulse) begin
                phase_reg     <= table_rd;
                hop_index_reg <= idx_reg;
            end
        end
    end

    assign o_phase_inc       = pulse ? table_rd : phase_reg;
    assign o_phase_inc_valid = pulse;
    assign o_hop_index       = pulse ? idx_reg : hop_index_reg;
    assign o_busy            = (state_reg != IDLE);

`ifdef RX_HOP_COUNT_EN
    logic [31:0] hop_count_reg;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hop_count_reg <= '0;
        end else if ((state_reg == IDLE) && start_ok && !i_stop) begin
            hop_count_reg <= '0;
        end else if (pulse && (hop_count_reg != 32'hFFFF_FFFF)) begin
            hop_count_reg <= hop_count_reg + 32'd1;
        end
    end

    assign o_hop_count = hop_count_reg;
`endif

endmodule

// File: tb/tb_rx_channel_hop_scheduler.sv
// Directed bench for rx_channel_hop_scheduler: hop sequencing, PEND hold-off, stop and reset behaviour.
module tb_rx_channel_hop_scheduler;

    logic        clk;
    logic        i_reset;
    logic        i_cfg_wr;
    logic [3:0]  i_cfg_addr;
    logic [11:0] i_cfg_chan;
    logic [4:0]  i_cfg_len;
    logic [15:0] i_cfg_dwell;
    logic        i_start;
    logic        i_stop;
    logic        i_valid;
    logic [11:0] o_phase_inc;
    logic        o_phase_inc_valid;
    logic [3:0]  o_hop_index;
    logic        o_busy;
`ifdef RX_HOP_COUNT_EN
    logic [31:0] o_hop_count;
`endif

    int errors = 0;
    int checks = 0;

    rx_channel_hop_scheduler dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_cfg_wr         (i_cfg_wr),
        .i_cfg_addr       (i_cfg_addr),
        .i_cfg_chan       (i_cfg_chan),
        .i_cfg_len        (i_cfg_len),
        .i_cfg_dwell      (i_cfg_dwell),
        .i_start          (i_start),
        .i_stop           (i_stop),
        .i_valid          (i_valid),
        .o_phase_inc      (o_phase_inc),
        .o_phase_inc_valid(o_phase_inc_valid),
        .o_hop_index      (o_hop_index),
        .o_busy           (o_busy)
`ifdef RX_HOP_COUNT_EN
        ,
        .o_hop_count      (o_hop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: inputs change just after the rising edge, outputs sampled at the falling edge.
    task automatic cyc(input logic v = 1'b0, input logic st = 1'b0, input logic sp = 1'b0,
                       input logic wr = 1'b0, input logic [3:0] a = 4'd0, input logic [11:0] ch = 12'd0);
        @(posedge clk);
        #1;
        i_valid    = v;
        i_start    = st;
        i_stop     = sp;
        i_cfg_wr   = wr;
        i_cfg_addr = a;
        i_cfg_chan = ch;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int pulses;
        i_reset = 1'b1;
        cyc();
        cyc();
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_phase_inc_valid !== 1'b0 || o_phase_inc !== 12'd0 || o_hop_index !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b phase=%0d idx=%0d, required all 0",
                     o_busy, o_phase_inc_valid, o_phase_inc, o_hop_index);
        end
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(.v(c[0]));
            if (o_phase_inc_valid) pulses++;
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy: cycle %0d busy=%b, required 0", c, o_busy);
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_no_pulse: pulses=%0d, required 0", pulses);
        end
        $display("test_reset: done, %0d pulses while idle", pulses);
    endtask

    task automatic test_hop_sequence();
        int exp_phase [5] = '{5, 9, 17, 5, 9};
        int exp_idx   [5] = '{0, 1, 2, 0, 1};
        int pulses;
        int samples;
        int last_phase;
        cyc(.wr(1), .a(4'd0), .ch(12'd5));
        cyc(.wr(1), .a(4'd1), .ch(12'd9));
        cyc(.wr(1), .a(4'd2), .ch(12'd17));
        i_cfg_len   = 5'd3;
        i_cfg_dwell = 16'd4;
        cyc(.st(1));
        pulses     = 0;
        samples    = 0;
        last_phase = 0;
        for (int c = 0; c < 200 && pulses < 5; c++) begin
            cyc(.v(c[0] == 1'b0));
            if (o_phase_inc_valid) begin
                checks++;
                if (o_phase_inc !== 12'(exp_phase[pulses]) || o_hop_index !== 4'(exp_idx[pulses])) begin
                    errors++;
                    $display("FAIL hop_value: pulse %0d phase=%0d idx=%0d, required phase=%0d idx=%0d",
                             pulses, o_phase_inc, o_hop_index, exp_phase[pulses], exp_idx[pulses]);
                end
                if (pulses > 0) begin
                    checks++;
                    if (samples != 4) begin
                        errors++;
                        $display("FAIL hop_dwell: pulse %0d saw %0d samples, required 4", pulses, samples);
                    end
                end
                $display("test_hop_sequence: pulse %0d phase=%0d idx=%0d samples=%0d",
                         pulses, o_phase_inc, o_hop_index, samples);
                last_phase = int'(o_phase_inc);
                pulses++;
                samples = 0;
            end else begin
                if (i_valid) samples++;
                if (pulses > 0) begin
                    checks++;
                    if (o_phase_inc !== 12'(last_phase)) begin
                        errors++;
                        $display("FAIL hop_hold: phase=%0d, required %0d", o_phase_inc, last_phase);
                    end
                end
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL hop_timeout: %0d pulses, required 5", pulses);
        end
        cyc(.sp(1));
        cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL hop_stop_busy: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_pend_hold();
        int early;
        i_cfg_len   = 5'd3;
        i_cfg_dwell = 16'd4;
        cyc(.st(1));
        early = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(.v(1));
            if (o_phase_inc_valid) early++;
        end
        checks++;
        if (early != 0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_hold: early pulses=%0d busy=%b, required 0 and 1", early, o_busy);
        end
        cyc(.v(0));
        checks++;
        if (o_phase_inc_valid !== 1'b1 || o_phase_inc !== 12'd5) begin
            errors++;
            $display("FAIL pend_release: valid=%b phase=%0d, required 1 and 5", o_phase_inc_valid, o_phase_inc);
        end
        $display("test_pend_hold: release pulse valid=%b phase=%0d", o_phase_inc_valid, o_phase_inc);
        cyc(.sp(1));
    endtask

    task automatic test_stop_on_completion();
        cyc(.st(1));
        cyc(.v(0));
        checks++;
        if (o_phase_inc_valid !== 1'b1 || o_phase_inc !== 12'd5) begin
            errors++;
            $display("FAIL stop_first_pulse: valid=%b phase=%0d, required 1 and 5", o_phase_inc_valid, o_phase_inc);
        end
        cyc(.v(1));
        cyc(.v(1));
        cyc(.v(1));
        cyc(.v(1), .sp(1));
        checks++;
        if (o_phase_inc_valid !== 1'b0 || o_phase_inc !== 12'd5) begin
            errors++;
            $display("FAIL stop_same_cycle: valid=%b phase=%0d, required 0 and 5", o_phase_inc_valid, o_phase_inc);
        end
        cyc();
        checks++;
        if (o_busy !== 1'b0 || o_phase_inc_valid !== 1'b0 || o_phase_inc !== 12'd5) begin
            errors++;
            $display("FAIL stop_after: busy=%b valid=%b phase=%0d, required 0, 0, 5",
                     o_busy, o_phase_inc_valid, o_phase_inc);
        end
        $display("test_stop_on_completion: busy=%b phase=%0d", o_busy, o_phase_inc);
    endtask

    task automatic test_single_entry();
        int pulses;
        int expv;
        cyc(.wr(1), .a(4'd0), .ch(12'd33));
        i_cfg_len   = 5'd1;
        i_cfg_dwell = 16'd1;
        cyc(.st(1));
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 13)      cyc(.v(1), .wr(1), .a(4'd0), .ch(12'd44));
            else if (c == 17) cyc(.v(0), .wr(1), .a(4'd0), .ch(12'd55));
            else              cyc(.v((c % 3) != 2));
            expv = (c <= 11) ? 33 : (c <= 17) ? 44 : 55;
            checks++;
            if (o_phase_inc_valid !== ((c % 3) == 2) || o_hop_index !== 4'd0) begin
                errors++;
                $display("FAIL single_timing: cycle %0d valid=%b idx=%0d, required valid=%b idx=0",
                         c, o_phase_inc_valid, o_hop_index, ((c % 3) == 2));
            end
            if (o_phase_inc_valid) begin
                pulses++;
                checks++;
                if (o_phase_inc !== 12'(expv)) begin
                    errors++;
                    $display("FAIL single_value: cycle %0d phase=%0d, required %0d", c, o_phase_inc, expv);
                end
            end
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL single_count: %0d pulses, required 10", pulses);
        end
        $display("test_single_entry: %0d pulses", pulses);
        cyc(.sp(1));
    endtask

    task automatic test_start_guard();
        i_cfg_len   = 5'd0;
        i_cfg_dwell = 16'd4;
        cyc(.st(1));
        cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_len0: busy=%b, required 0", o_busy);
        end
        i_cfg_len   = 5'd3;
        i_cfg_dwell = 16'd0;
        cyc(.st(1));
        cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_dwell0: busy=%b, required 0", o_busy);
        end
        i_cfg_dwell = 16'd4;
        cyc(.st(1), .sp(1));
        cyc();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_stop: busy=%b, required 0", o_busy);
        end
        $display("test_start_guard: busy=%b", o_busy);
    endtask

    task automatic test_reset_midhop();
        i_cfg_len   = 5'd3;
        i_cfg_dwell = 16'd4;
        cyc(.st(1));
        cyc(.v(0));
        checks++;
        if (o_phase_inc_valid !== 1'b1 || o_phase_inc !== 12'd55) begin
            errors++;
            $display("FAIL midhop_pulse: valid=%b phase=%0d, required 1 and 55", o_phase_inc_valid, o_phase_inc);
        end
        cyc(.v(1));
        @(posedge clk);
        #1 i_reset = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_phase_inc !== 12'd0 || o_hop_index !== 4'd0 || o_phase_inc_valid !== 1'b0) begin
            errors++;
            $display("FAIL midhop_reset: busy=%b phase=%0d idx=%0d valid=%b, required all 0",
                     o_busy, o_phase_inc, o_hop_index, o_phase_inc_valid);
        end
        $display("test_reset_midhop: busy=%b phase=%0d", o_busy, o_phase_inc);
    endtask

`ifdef RX_HOP_COUNT_EN
    task automatic test_hop_count();
        int pulses;
        i_cfg_len   = 5'd3;
        i_cfg_dwell = 16'd1;
        cyc(.st(1));
        pulses = 0;
        for (int c = 0; c < 100 && pulses < 7; c++) begin
            cyc(.v(c[0]));
            if (o_phase_inc_valid) pulses++;
        end
        cyc(.sp(1));
        checks++;
        if (o_hop_count !== 32'd7) begin
            errors++;
            $display("FAIL hop_count_7: count=%0d, required 7", o_hop_count);
        end
        cyc(.st(1));
        cyc(.v(1));
        checks++;
        if (o_hop_count !== 32'd0) begin
            errors++;
            $display("FAIL hop_count_clear: count=%0d, required 0", o_hop_count);
        end
        $display("test_hop_count: count=%0d after restart", o_hop_count);
        cyc(.sp(1));
    endtask
`endif

    initial begin
        i_reset     = 1'b0;
        i_cfg_wr    = 1'b0;
        i_cfg_addr  = '0;
        i_cfg_chan  = '0;
        i_cfg_len   = '0;
        i_cfg_dwell = '0;
        i_start     = 1'b0;
        i_stop      = 1'b0;
        i_valid     = 1'b0;
        test_reset();
        test_hop_sequence();
        test_pend_hold();
        test_stop_on_completion();
        test_single_entry();
        test_start_guard();
        test_reset_midhop();
`ifdef RX_HOP_COUNT_EN
        test_hop_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
